multicycle_control: RTL
=======================

# multicycle_control

Main control unit of the multicycle datapath, directly upstream of the ALU control decoder. Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction from the 4-bit opcode in the instruction register. Emits every datapath enable/select plus the 3-bit `ALUOp` and 3-bit `funk` pass-through consumed by the ALU control decoder.

## Interface
Parameters:
- `STATE_W`, 4, width of the state register and `state` debug port.

Ports (clock/reset first):
- `CLK`  in  1  single system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  4  IR[15:12].
- `funk_in`  in  3  IR[2:0].
- `ALUOp`  out  3  to ALU control: 0 R-type, 1 shift-imm, 2 add, 3 sub, 7 slt.
- `funk`  out  3  registered copy of `funk_in`, captured in DECODE.
- `PCWrite`, `PCWriteCond`, `BranchNE`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath controls.
- `ALUSrcB`  out  2  0 regB, 1 const 2, 2 sign-ext imm, 3 shifted imm.
- `PCSource`  out  2  0 ALU result, 1 ALUOut, 2 jump target.
- `Illegal`  out  1  one-cycle pulse on undefined opcode.
- `Halted`  out  1  high while in HALT.
- `state`  out  STATE_W  current state, debug.

## Operation
- Opcodes: 0 R-type, 1 shift-imm, 2 addi, 3 lw, 4 sw, 5 beq, 6 bne, 7 j, 8 slti, 15 halt; 9–14 illegal.
- States: RST, FETCH, DECODE, EX_R, EX_SH, EX_I, EX_SLTI, R_WB, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT (16 → 4 bits).
- RST → FETCH unconditionally. FETCH → DECODE. DECODE dispatches: 0→EX_R, 1→EX_SH, 2→EX_I, 8→EX_SLTI, 3/4→MEM_ADDR, 5/6→BRANCH, 7→JUMP, 15→HALT, illegal→FETCH with `Illegal`=1 that cycle.
- EX_R/EX_SH → R_WB; EX_I/EX_SLTI → I_WB; MEM_ADDR → MEM_RD (lw) or MEM_WR (sw); MEM_RD → MEM_WB; R_WB, I_WB, MEM_WB, MEM_WR, BRANCH, JUMP → FETCH. HALT self-loops until reset.
- Outputs are a function of state only (Moore); any output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=1, ALUOp=2, PCSource=0.
  - DECODE: ALUSrcB=3, ALUOp=2 (branch target into ALUOut); capture `funk`.
  - EX_R: ALUSrcA=1, ALUOp=0. EX_SH: ALUSrcA=1, ALUSrcB=2, ALUOp=1. EX_I: ALUSrcA=1, ALUSrcB=2, ALUOp=2. EX_SLTI: same with ALUOp=7.
  - R_WB: RegWrite, RegDst=1. I_WB: RegWrite, RegDst=0.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=2. MEM_RD: MemRead, IorD. MEM_WB: RegWrite, MemtoReg. MEM_WR: MemWrite, IorD.
  - BRANCH: ALUSrcA=1, ALUOp=3, PCWriteCond, PCSource=1, BranchNE=(opcode latched ==6).
  - JUMP: PCWrite, PCSource=2. HALT: `Halted`=1.
- Opcode for MEM_ADDR/BRANCH selection uses a copy latched in DECODE, not live `opcode`.

## Timing
- Reset asserted: state=RST, every output 0 including `funk`, `Illegal`, `Halted`; takes effect asynchronously, mid-instruction included (no partial write-back after reset edge).
- First FETCH is the cycle after `Reset` deasserts.
- Latency in cycles, FETCH to next FETCH: R/shift/addi/slti 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- `IRWrite` and `PCWrite` high for exactly one cycle per instruction (FETCH), except jumps where `PCWrite` also pulses in JUMP.
- `funk` stable from the cycle after DECODE until the next DECODE.
- Never assert `MemRead` and `MemWrite` together; never `RegWrite` outside R_WB/I_WB/MEM_WB.

## Structure
- Shared package: opcode constants, ALUOp encodings (must match ALU control decoder), state encodings, ALUSrcB/PCSource encodings.
- One sub-module natural: `control_output_decode`, combinational state → control-vector decoder; top holds state register, latched opcode/funk, next-state logic.

## Test plan
- Reset low mid-MEM_RD of lw → all outputs 0 immediately; release → RST, then FETCH with MemRead=IRWrite=PCWrite=1.
- opcode 0, funk 3 → states FETCH, DECODE, EX_R (ALUOp=0, funk=3), R_WB (RegWrite, RegDst=1), FETCH: 4 cycles.
- opcode 3 → 5-cycle lw sequence; MEM_RD has IorD=1, MemRead=1; MEM_WB has MemtoReg=1, RegWrite=1.
- opcode 6 → BRANCH with ALUOp=3, PCWriteCond=1, BranchNE=1, PCSource=1; back to FETCH in 3 cycles.
- opcode 11 → `Illegal` pulses one cycle in DECODE, no RegWrite/MemWrite, FETCH next.
- opcode 15 → HALT, `Halted`=1 held for 20 cycles with opcode changing; only reset exits.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle main control unit.
//   - opcode constants (IR[15:12])
//   - ALUOp encodings consumed by the ALU control decoder
//   - ALUSrcB / PCSource select encodings
//   - FSM state encoding and the packed control vector
package multicycle_control_pkg;

   localparam logic [3:0] OP_RTYPE = 4'd0;
   localparam logic [3:0] OP_SHIFT = 4'd1;
   localparam logic [3:0] OP_ADDI  = 4'd2;
   localparam logic [3:0] OP_LW    = 4'd3;
   localparam logic [3:0] OP_SW    = 4'd4;
   localparam logic [3:0] OP_BEQ   = 4'd5;
   localparam logic [3:0] OP_BNE   = 4'd6;
   localparam logic [3:0] OP_J     = 4'd7;
   localparam logic [3:0] OP_SLTI  = 4'd8;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [2:0] ALUOP_RTYPE = 3'd0;
   localparam logic [2:0] ALUOP_SHIFT = 3'd1;
   localparam logic [2:0] ALUOP_ADD   = 3'd2;
   localparam logic [2:0] ALUOP_SUB   = 3'd3;
   localparam logic [2:0] ALUOP_SLT   = 3'd7;

   localparam logic [1:0] SRCB_REGB   = 2'd0;
   localparam logic [1:0] SRCB_CONST2 = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EX_R     = 4'd3,
      S_EX_SH    = 4'd4,
      S_EX_I     = 4'd5,
      S_EX_SLTI  = 4'd6,
      S_R_WB     = 4'd7,
      S_I_WB     = 4'd8,
      S_MEM_ADDR = 4'd9,
      S_MEM_RD   = 4'd10,
      S_MEM_WB   = 4'd11,
      S_MEM_WR   = 4'd12,
      S_BRANCH   = 4'd13,
      S_JUMP     = 4'd14,
      S_HALT     = 4'd15
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       halted;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Opcodes 9..14 have no instruction assigned.
   function automatic logic op_is_illegal(input logic [3:0] op);
      return (op >= 4'd9) && (op <= 4'd14);
   endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// control_output_decode: combinational state -> control-vector decoder.
// Ports:
//   i_state     : current FSM state encoding
//   i_branch_ne : latched opcode was bne (only meaningful in BRANCH)
//   o_ctrl      : packed ctrl_t control vector
module control_output_decode
   import multicycle_control_pkg::*;
(
   input  logic [3:0]        i_state,
   input  logic              i_branch_ne,
   output logic [CTRL_W-1:0] o_ctrl
);

   ctrl_t w_ctrl;

   always_comb begin
      w_ctrl = '0;
      case (state_t'(i_state))
         S_FETCH: begin
            w_ctrl.mem_read  = 1'b1;
            w_ctrl.ir_write  = 1'b1;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.alu_src_b = SRCB_CONST2;
            w_ctrl.alu_op    = ALUOP_ADD;
            w_ctrl.pc_source = PCSRC_ALU;
         end
         // Branch target is computed speculatively into ALUOut here.
         S_DECODE: begin
            w_ctrl.alu_src_b = SRCB_IMM_SH;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         S_EX_R: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_op    = ALUOP_RTYPE;
         end
         S_EX_SH: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_SHIFT;
         end
         S_EX_I, S_MEM_ADDR: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_ADD;
         end
         S_EX_SLTI: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = SRCB_IMM;
            w_ctrl.alu_op    = ALUOP_SLT;
         end
         S_R_WB: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.reg_dst   = 1'b1;
         end
         S_I_WB: begin
            w_ctrl.reg_write = 1'b1;
         end
         S_MEM_RD: begin
            w_ctrl.mem_read = 1'b1;
            w_ctrl.iord     = 1'b1;
         end
         S_MEM_WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            w_ctrl.mem_write = 1'b1;
            w_ctrl.iord      = 1'b1;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a     = 1'b1;
            w_ctrl.alu_op        = ALUOP_SUB;
            w_ctrl.pc_write_cond = 1'b1;
            w_ctrl.pc_source     = PCSRC_ALUOUT;
            w_ctrl.branch_ne     = i_branch_ne;
         end
         S_JUMP: begin
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = PCSRC_JUMP;
         end
         S_HALT: begin
            w_ctrl.halted = 1'b1;
         end
         default: begin
            w_ctrl = '0;
         end
      endcase
   end

   assign o_ctrl = w_ctrl;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main control FSM of the multicycle datapath.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITE-BACK from the IR opcode.
// Ports:
//   CLK, Reset (async, active-low)
//   opcode, funk_in         : IR[15:12], IR[2:0]
//   ALUOp, funk             : to ALU control decoder (funk captured in DECODE)
//   PCWrite..ALUSrcA        : single-bit datapath controls
//   ALUSrcB, PCSource       : datapath mux selects
//   Illegal                 : pulse in DECODE on an undefined opcode
//   Halted                  : high while in HALT
//   state                   : current FSM state, debug
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [3:0]         opcode,
   input  logic [2:0]         funk_in,
   output logic [2:0]         ALUOp,
   output logic [2:0]         funk,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               BranchNE,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               MemtoReg,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic               Illegal,
   output logic               Halted,
   output logic [STATE_W-1:0] state
);

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_opcode;
   logic [2:0]          r_funk;
   logic [CTRL_W-1:0]   w_ctrl_vec;
   ctrl_t               w_ctrl;

   // Opcode and funk are latched at the end of DECODE so later states do
   // not depend on the IR staying put.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_RST;
         r_opcode <= 4'd0;
         r_funk   <= 3'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode <= opcode;
            r_funk   <= funk_in;
         end
      end
   end

   // DECODE dispatches on the live opcode: the latched copy is only written
   // at the end of that cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RST:    w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     w_next = S_EX_R;
               OP_SHIFT:     w_next = S_EX_SH;
               OP_ADDI:      w_next = S_EX_I;
               OP_SLTI:      w_next = S_EX_SLTI;
               OP_LW, OP_SW: w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE: w_next = S_BRANCH;
               OP_J:         w_next = S_JUMP;
               OP_HALT:      w_next = S_HALT;
               default:      w_next = S_FETCH;
            endcase
         end
         S_EX_R, S_EX_SH:    w_next = S_R_WB;
         S_EX_I, S_EX_SLTI:  w_next = S_I_WB;
         S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   w_next = S_MEM_WB;
         S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP:
                     w_next = S_FETCH;
         S_HALT:     w_next = S_HALT;
         default:    w_next = S_RST;
      endcase
   end

   control_output_decode u_decode (
      .i_state     (r_state),
      .i_branch_ne (r_opcode == OP_BNE),
      .o_ctrl      (w_ctrl_vec)
   );

   assign w_ctrl      = ctrl_t'(w_ctrl_vec);
   assign ALUOp       = w_ctrl.alu_op;
   assign PCWrite     = w_ctrl.pc_write;
   assign PCWriteCond = w_ctrl.pc_write_cond;
   assign BranchNE    = w_ctrl.branch_ne;
   assign IorD        = w_ctrl.iord;
   assign MemRead     = w_ctrl.mem_read;
   assign MemWrite    = w_ctrl.mem_write;
   assign IRWrite     = w_ctrl.ir_write;
   assign MemtoReg    = w_ctrl.mem_to_reg;
   assign RegWrite    = w_ctrl.reg_write;
   assign RegDst      = w_ctrl.reg_dst;
   assign ALUSrcA     = w_ctrl.alu_src_a;
   assign ALUSrcB     = w_ctrl.alu_src_b;
   assign PCSource    = w_ctrl.pc_source;
   assign Halted      = w_ctrl.halted;
   assign funk        = r_funk;
   assign Illegal     = (r_state == S_DECODE) && op_is_illegal(opcode);
   assign state       = STATE_W'(r_state);

endmodule
